// File: rtl/wash_pkg.sv
// ============================================================================
// Module      : wash_pkg
// Description : Shared encodings, program masks and stage-timing helpers for
//               the washing-machine control core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wash_pkg;

    typedef enum logic [2:0] {
        ST_SHUTDOWN = 3'd0,
        ST_BEGIN    = 3'd1,
        ST_SET      = 3'd2,
        ST_RUN      = 3'd3,
        ST_ERROR    = 3'd4,
        ST_PAUSE    = 3'd5,
        ST_FINISH   = 3'd6
    } wash_state_e;

    typedef enum logic [5:0] {
        DISP_EMPTY = 6'd55,
        DISP_FULL  = 6'd56,
        DISP_PAUSE = 6'd57,
        DISP_ERROR = 6'd58,
        DISP_HE    = 6'd59,
        DISP_LL    = 6'd60,
        DISP_O     = 6'd61
    } disp_code_e;

    localparam int unsigned MODE_COUNT = 6;
    localparam int unsigned WEIGHT_MAX = 5;

    function automatic logic [7:0] mode_mask(input logic [2:0] mode);
        case (mode)
            3'd0:    return 8'hFF;
            3'd1:    return 8'hC0;
            3'd2:    return 8'hFC;
            3'd3:    return 8'h3F;
            3'd4:    return 8'h03;
            3'd5:    return 8'h3C;
            default: return 8'hFF;
        endcase
    endfunction

    // Bit7..bit0: inWater, wash, outWater, spin, inWater, rinse, outWater, spin
    function automatic logic [1:0] stage_mult(input logic [2:0] bit_idx);
        case (bit_idx)
            3'd6:    return 2'd3;
            3'd2:    return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [6:0] duration(input logic [2:0] bit_idx,
                                            input logic [2:0] weight);
        return 7'(stage_mult(bit_idx)) * 7'(weight);
    endfunction

    function automatic logic [6:0] total_time(input logic [7:0] mask,
                                              input logic [2:0] weight);
        logic [6:0] sum;
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                sum = sum + duration(3'(i), weight);
            end
        end
        return sum;
    endfunction

    // Stages run from bit7 downwards, so the highest set bit is the next one.
    function automatic logic [2:0] highest_bit(input logic [7:0] mask);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/second_tick.sv
// ============================================================================
// Module      : second_tick
// Description : Registered rising-edge detector turning the 1 Hz square wave
//               into a one-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module second_tick (
    input  logic cp,
    input  logic reset,
    input  logic second,
    output logic tick
);

    logic r_prev;
    logic r_tick;

    // r_prev resets high so a wave already high at reset release is not a tick.
    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_prev <= second;
            r_tick <= second & ~r_prev;
        end
    end

    assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/wash_controller.sv
// ============================================================================
// Module      : wash_controller
// Description : Washing-machine control core: power/set/run/pause/error/finish
//               sequencing, stage scheduling and remaining-time countdown.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wash_controller
    import wash_pkg::*;
#(
    parameter int BEGIN_SEC      = 2,
    parameter int FINISH_SEC     = 5,
    parameter int CLICK_CYCLES   = 16,
    parameter int DEFAULT_WEIGHT = 3
) (
    input  logic       cp,
    input  logic       reset,
    input  logic       second,
    input  logic       powerBtn,
    input  logic       startBtn,
    input  logic       modeBtn,
    input  logic       weightBtn,
    input  logic       lidOpen,
    output logic [2:0] state,
    output logic [9:0] data,
    output logic [2:0] shinning,
    output logic       click,
    output logic [5:0] inLeft,
    output logic [5:0] inMiddle,
    output logic [5:0] inRight
);

    localparam int SEC_MAX = (BEGIN_SEC > FINISH_SEC) ? BEGIN_SEC : FINISH_SEC;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);
    localparam int CLICK_W = $clog2(CLICK_CYCLES + 1);

    localparam logic [SEC_W-1:0]   c_begin_last   = SEC_W'(BEGIN_SEC - 1);
    localparam logic [SEC_W-1:0]   c_finish_last  = SEC_W'(FINISH_SEC - 1);
    localparam logic [CLICK_W-1:0] c_click_load   = CLICK_W'(CLICK_CYCLES);
    localparam logic [2:0]         c_def_weight   = 3'(DEFAULT_WEIGHT);
    localparam logic [2:0]         c_last_mode    = 3'(MODE_COUNT - 1);
    localparam logic [2:0]         c_weight_max   = 3'(WEIGHT_MAX);

    wash_state_e        r_state;
    logic [2:0]         r_mode;
    logic [2:0]         r_weight;
    logic [2:0]         r_shinning;
    logic [7:0]         r_mask;
    logic [6:0]         r_remaining;
    logic [6:0]         r_stage_cnt;
    logic [SEC_W-1:0]   r_sec_cnt;
    logic [CLICK_W-1:0] r_click_cnt;

    logic       w_tick;
    logic [2:0] w_first_bit;
    logic [2:0] w_cur_bit;
    logic [7:0] w_mask_after;
    logic [2:0] w_next_bit;
    logic [6:0] w_total;
    logic [6:0] w_time;
    logic [2:0] w_mode_next;
    logic [2:0] w_weight_next;

    second_tick u_second_tick (
        .cp     (cp),
        .reset  (reset),
        .second (second),
        .tick   (w_tick)
    );

    assign w_first_bit   = highest_bit(r_mask);
    assign w_cur_bit     = 3'd7 - r_shinning;
    assign w_mask_after  = r_mask & ~(8'b1 << w_cur_bit);
    assign w_next_bit    = highest_bit(w_mask_after);
    assign w_total       = total_time(r_mask, r_weight);
    assign w_mode_next   = (r_mode == c_last_mode) ? 3'd0 : r_mode + 3'd1;
    assign w_weight_next = (r_weight == c_weight_max) ? 3'd1 : r_weight + 3'd1;

    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SHUTDOWN;
            r_mode      <= 3'd0;
            r_weight    <= c_def_weight;
            r_shinning  <= 3'd0;
            r_mask      <= mode_mask(3'd0);
            r_remaining <= 7'd0;
            r_stage_cnt <= 7'd0;
            r_sec_cnt   <= '0;
            r_click_cnt <= '0;
        end else begin
            if (r_click_cnt != '0) begin
                r_click_cnt <= r_click_cnt - CLICK_W'(1);
            end

            if (powerBtn) begin
                r_click_cnt <= c_click_load;
                r_sec_cnt   <= '0;
                if (r_state == ST_SHUTDOWN) begin
                    r_state <= ST_BEGIN;
                end else begin
                    r_state     <= ST_SHUTDOWN;
                    r_mask      <= mode_mask(r_mode);
                    r_remaining <= 7'd0;
                    r_stage_cnt <= 7'd0;
                    r_shinning  <= 3'd0;
                end
            end else begin
                unique case (r_state)
                    ST_SHUTDOWN: ;

                    ST_BEGIN: begin
                        if (w_tick) begin
                            if (r_sec_cnt == c_begin_last) begin
                                r_state   <= ST_SET;
                                r_mask    <= mode_mask(r_mode);
                                r_sec_cnt <= '0;
                            end else begin
                                r_sec_cnt <= r_sec_cnt + SEC_W'(1);
                            end
                        end
                    end

                    ST_SET: begin
                        if (startBtn) begin
                            r_state     <= ST_RUN;
                            r_remaining <= w_total;
                            r_stage_cnt <= duration(w_first_bit, r_weight);
                            r_shinning  <= 3'd7 - w_first_bit;
                            r_click_cnt <= c_click_load;
                        end else begin
                            if (modeBtn) begin
                                r_mode      <= w_mode_next;
                                r_mask      <= mode_mask(w_mode_next);
                                r_click_cnt <= c_click_load;
                            end
                            if (weightBtn) begin
                                r_weight    <= w_weight_next;
                                r_click_cnt <= c_click_load;
                            end
                        end
                    end

                    // Leaving run takes priority over a coincident tick.
                    ST_RUN: begin
                        if (lidOpen) begin
                            r_state <= ST_ERROR;
                        end else if (startBtn) begin
                            r_state     <= ST_PAUSE;
                            r_click_cnt <= c_click_load;
                        end else if (w_tick) begin
                            r_remaining <= r_remaining - 7'd1;
                            if (r_stage_cnt == 7'd1) begin
                                r_mask <= w_mask_after;
                                if (w_mask_after == 8'h00) begin
                                    r_state     <= ST_FINISH;
                                    r_stage_cnt <= 7'd0;
                                    r_sec_cnt   <= '0;
                                end else begin
                                    r_stage_cnt <= duration(w_next_bit, r_weight);
                                    r_shinning  <= 3'd7 - w_next_bit;
                                end
                            end else begin
                                r_stage_cnt <= r_stage_cnt - 7'd1;
                            end
                        end
                    end

                    ST_PAUSE: begin
                        if (startBtn) begin
                            r_state     <= ST_RUN;
                            r_click_cnt <= c_click_load;
                        end
                    end

                    ST_ERROR: begin
                        if (startBtn && !lidOpen) begin
                            r_state     <= ST_RUN;
                            r_click_cnt <= c_click_load;
                        end
                    end

                    ST_FINISH: begin
                        if (startBtn || modeBtn || weightBtn) begin
                            r_state     <= ST_SHUTDOWN;
                            r_mask      <= mode_mask(r_mode);
                            r_shinning  <= 3'd0;
                            r_sec_cnt   <= '0;
                            r_click_cnt <= c_click_load;
                        end else if (w_tick) begin
                            if (r_sec_cnt == c_finish_last) begin
                                r_state    <= ST_SHUTDOWN;
                                r_mask     <= mode_mask(r_mode);
                                r_shinning <= 3'd0;
                                r_sec_cnt  <= '0;
                            end else begin
                                r_sec_cnt <= r_sec_cnt + SEC_W'(1);
                            end
                        end
                    end

                    default: r_state <= ST_SHUTDOWN;
                endcase
            end
        end
    end

    // In set the display previews the program length; afterwards it counts down.
    assign w_time = (r_state == ST_SET) ? w_total : r_remaining;

    always_comb begin
        data     = 10'd0;
        inLeft   = 6'd0;
        inMiddle = 6'd0;
        inRight  = 6'd0;
        case (r_state)
            ST_SHUTDOWN: ;
            ST_BEGIN: begin
                data     = {2'b01, 8'h00};
                inLeft   = DISP_HE;
                inMiddle = DISP_LL;
                inRight  = DISP_O;
            end
            default: begin
                data     = {(r_state == ST_SET), 1'b1, r_mask};
                inLeft   = {3'b000, r_weight};
                inMiddle = 6'(w_time / 7'd10);
                inRight  = 6'(w_time % 7'd10);
            end
        endcase
    end

    assign state    = r_state;
    assign shinning = r_shinning;
    assign click    = (r_click_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_wash_controller.sv
// ============================================================================
// Module      : tb_wash_controller
// Description : Directed scoreboard bench for wash_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wash_controller;

    logic       cp = 1'b0;
    logic       reset = 1'b1;
    logic       second = 1'b0;
    logic       powerBtn = 1'b0;
    logic       startBtn = 1'b0;
    logic       modeBtn = 1'b0;
    logic       weightBtn = 1'b0;
    logic       lidOpen = 1'b0;
    logic [2:0] state;
    logic [9:0] data;
    logic [2:0] shinning;
    logic       click;
    logic [5:0] inLeft;
    logic [5:0] inMiddle;
    logic [5:0] inRight;

    wash_controller dut (
        .cp        (cp),
        .reset     (reset),
        .second    (second),
        .powerBtn  (powerBtn),
        .startBtn  (startBtn),
        .modeBtn   (modeBtn),
        .weightBtn (weightBtn),
        .lidOpen   (lidOpen),
        .state     (state),
        .data      (data),
        .shinning  (shinning),
        .click     (click),
        .inLeft    (inLeft),
        .inMiddle  (inMiddle),
        .inRight   (inRight)
    );

    always #5 cp = ~cp;

    localparam logic [4:0] F_ST   = 5'b00001;
    localparam logic [4:0] F_DATA = 5'b00010;
    localparam logic [4:0] F_SH   = 5'b00100;
    localparam logic [4:0] F_CLK  = 5'b01000;
    localparam logic [4:0] F_DIG  = 5'b10000;
    localparam logic [4:0] F_ALL  = 5'b11111;

    localparam logic [3:0] B_PWR   = 4'b1000;
    localparam logic [3:0] B_START = 4'b0100;
    localparam logic [3:0] B_MODE  = 4'b0010;
    localparam logic [3:0] B_WGT   = 4'b0001;

    typedef struct packed {
        logic [4:0] cm;
        logic [2:0] st;
        logic [9:0] dat;
        logic [2:0] sh;
        logic       ck;
        logic [5:0] l;
        logic [5:0] m;
        logic [5:0] r;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    // Monitor: every queued expectation is judged against the outputs at the next falling edge.
    initial begin
        forever begin
            @(negedge cp);
            while (exp_q.size() > 0) begin
                exp_t  e;
                string nm;
                bit    bad;
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                bad = 1'b0;
                if (e.cm[0] && (state    !== e.st))  bad = 1'b1;
                if (e.cm[1] && (data     !== e.dat)) bad = 1'b1;
                if (e.cm[2] && (shinning !== e.sh))  bad = 1'b1;
                if (e.cm[3] && (click    !== e.ck))  bad = 1'b1;
                if (e.cm[4] && ((inLeft !== e.l) || (inMiddle !== e.m) || (inRight !== e.r))) bad = 1'b1;
                n_vec++;
                if (bad) begin
                    n_miss++;
                    $display("FAIL %s: got st=%0d data=%h sh=%0d click=%b dig=%0d/%0d/%0d, want st=%0d data=%h sh=%0d click=%b dig=%0d/%0d/%0d (fields %b)",
                             nm, state, data, shinning, click, inLeft, inMiddle, inRight,
                             e.st, e.dat, e.sh, e.ck, e.l, e.m, e.r, e.cm);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge cp);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        {powerBtn, startBtn, modeBtn, weightBtn} = b;
        cyc();
        {powerBtn, startBtn, modeBtn, weightBtn} = 4'b0000;
    endtask

    task automatic tick();
        second = 1'b1;
        cyc();
        cyc();
        second = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic chk(input string nm, input logic [4:0] cm, input logic [2:0] st,
                       input logic [9:0] dat, input logic [2:0] sh, input logic ck,
                       input logic [5:0] l, input logic [5:0] m, input logic [5:0] r);
        exp_t e;
        e = '{cm: cm, st: st, dat: dat, sh: sh, ck: ck, l: l, m: m, r: r};
        exp_q.push_back(e);
        name_q.push_back(nm);
        cyc();
    endtask

    initial begin
        cyc();
        cyc();
        chk("reset_state", F_ALL, 3'd0, 10'h000, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        reset = 1'b0;
        cyc();

        // Power-on greeting, then set after two ticks with 33 s on the display
        press(B_PWR);
        chk("power_on", F_ST | F_DATA | F_CLK | F_DIG, 3'd1, 10'h100, 3'd0, 1'b1, 6'd59, 6'd60, 6'd61);
        tick();
        chk("begin_one_tick", F_ST | F_DATA, 3'd1, 10'h100, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        tick();
        chk("set_entry", F_ST | F_DATA | F_SH | F_DIG, 3'd2, 10'h3FF, 3'd0, 1'b0, 6'd3, 6'd3, 6'd3);

        // Mode C0, weight 1 -> 4 s program
        press(B_MODE);
        chk("mode1_w3", F_DATA | F_DIG, 3'd2, 10'h3C0, 3'd0, 1'b0, 6'd3, 6'd1, 6'd2);
        press(B_WGT);
        chk("mode1_w4", F_DIG, 3'd2, 10'h3C0, 3'd0, 1'b0, 6'd4, 6'd1, 6'd6);
        press(B_WGT);
        press(B_WGT);
        chk("mode1_w1", F_DATA | F_DIG, 3'd2, 10'h3C0, 3'd0, 1'b0, 6'd1, 6'd0, 6'd4);
        press(B_START);
        chk("run_start", F_ST | F_DATA | F_SH | F_DIG, 3'd3, 10'h1C0, 3'd0, 1'b0, 6'd1, 6'd0, 6'd4);
        tick();
        chk("run_stage2", F_ST | F_DATA | F_SH | F_DIG, 3'd3, 10'h140, 3'd1, 1'b0, 6'd1, 6'd0, 6'd3);
        tick();
        tick();
        chk("run_stage2_end", F_ST | F_DATA | F_SH | F_DIG, 3'd3, 10'h140, 3'd1, 1'b0, 6'd1, 6'd0, 6'd1);
        tick();
        chk("finish_mode1", F_ST | F_DATA | F_DIG, 3'd6, 10'h100, 3'd0, 1'b0, 6'd1, 6'd0, 6'd0);

        // Mode 4, weight 2, pause with ignored ticks, then resume
        press(B_PWR);
        chk("finish_power_off", F_ALL, 3'd0, 10'h000, 3'd0, 1'b1, 6'd0, 6'd0, 6'd0);
        press(B_PWR);
        tick();
        tick();
        chk("set_kept_mode", F_ST | F_DATA | F_DIG, 3'd2, 10'h3C0, 3'd0, 1'b0, 6'd1, 6'd0, 6'd4);
        for (int i = 0; i < 3; i++) press(B_MODE);
        chk("mode4_w1", F_DATA | F_DIG, 3'd2, 10'h303, 3'd0, 1'b0, 6'd1, 6'd0, 6'd2);
        press(B_WGT);
        chk("mode4_w2", F_DIG, 3'd2, 10'h303, 3'd0, 1'b0, 6'd2, 6'd0, 6'd4);
        press(B_START);
        chk("run4_start", F_ST | F_DATA | F_SH | F_DIG, 3'd3, 10'h103, 3'd6, 1'b0, 6'd2, 6'd0, 6'd4);
        tick();
        chk("run4_tick1", F_ST | F_SH | F_DIG, 3'd3, 10'h000, 3'd6, 1'b0, 6'd2, 6'd0, 6'd3);
        press(B_START);
        chk("pause", F_ST | F_DATA | F_DIG, 3'd5, 10'h103, 3'd0, 1'b0, 6'd2, 6'd0, 6'd3);
        for (int i = 0; i < 5; i++) tick();
        chk("pause_frozen", F_ST | F_SH | F_DIG, 3'd5, 10'h000, 3'd6, 1'b0, 6'd2, 6'd0, 6'd3);
        press(B_START);
        chk("resume", F_ST | F_DATA | F_SH | F_DIG, 3'd3, 10'h103, 3'd6, 1'b0, 6'd2, 6'd0, 6'd3);
        tick();
        chk("stage_bit0", F_ST | F_DATA | F_SH | F_DIG, 3'd3, 10'h101, 3'd7, 1'b0, 6'd2, 6'd0, 6'd2);
        tick();
        tick();
        chk("finish_mode4", F_ST | F_DATA | F_DIG, 3'd6, 10'h100, 3'd0, 1'b0, 6'd2, 6'd0, 6'd0);

        // Automatic power-off on the fifth tick in finish
        for (int i = 0; i < 4; i++) tick();
        chk("finish_hold", F_ST, 3'd6, 10'h000, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        tick();
        chk("auto_off", F_ST | F_DATA | F_DIG, 3'd0, 10'h000, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0);

        // Lid opened during run
        press(B_PWR);
        tick();
        tick();
        press(B_START);
        chk("run_before_lid", F_ST | F_SH | F_DIG, 3'd3, 10'h000, 3'd6, 1'b0, 6'd2, 6'd0, 6'd4);
        repeat (20) cyc();
        lidOpen = 1'b1;
        cyc();
        chk("lid_error", F_ST | F_DATA | F_CLK | F_DIG, 3'd4, 10'h103, 3'd0, 1'b0, 6'd2, 6'd0, 6'd4);
        tick();
        chk("error_frozen", F_ST | F_DIG, 3'd4, 10'h000, 3'd0, 1'b0, 6'd2, 6'd0, 6'd4);
        press(B_START);
        chk("error_start_lid_open", F_ST | F_CLK, 3'd4, 10'h000, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        lidOpen = 1'b0;
        cyc();
        press(B_START);
        chk("error_resume", F_ST | F_SH | F_CLK | F_DIG, 3'd3, 10'h000, 3'd6, 1'b1, 6'd2, 6'd0, 6'd4);
        tick();
        chk("after_resume_tick", F_ST | F_DIG, 3'd3, 10'h000, 3'd0, 1'b0, 6'd2, 6'd0, 6'd3);

        // Power and start together: power wins, click lasts 16 cycles
        {powerBtn, startBtn} = 2'b11;
        cyc();
        {powerBtn, startBtn} = 2'b00;
        chk("power_start_same", F_ALL, 3'd0, 10'h000, 3'd0, 1'b1, 6'd0, 6'd0, 6'd0);
        repeat (13) cyc();
        chk("click_cycle16", F_CLK, 3'd0, 10'h000, 3'd0, 1'b1, 6'd0, 6'd0, 6'd0);
        chk("click_cycle17", F_CLK, 3'd0, 10'h000, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0);

        // Short reset pulse between clock edges mid-run
        press(B_PWR);
        tick();
        tick();
        press(B_START);
        tick();
        chk("pre_reset_run", F_ST | F_DIG, 3'd3, 10'h000, 3'd0, 1'b0, 6'd2, 6'd0, 6'd3);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        chk("async_reset", F_ALL, 3'd0, 10'h000, 3'd0, 1'b0, 6'd0, 6'd0, 6'd0);
        press(B_PWR);
        tick();
        tick();
        chk("reset_defaults", F_ST | F_DATA | F_DIG, 3'd2, 10'h3FF, 3'd0, 1'b0, 6'd3, 6'd3, 6'd3);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) cyc();
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
